regfile_wr_arbiter: RTL and testbench

Write-port controller for `regfile32`. Two requesters share the register file's single write port: A is ALU writeback and B is load writeback. Conflicts are resolved round-robin. After reset, and on request, the block sequences a clear of registers 1–31, since `regfile32` reset clears only register 0. It drives `D_En`, `D_Addr` and `D` of `regfile32` directly from registers.

---
 rtl/regfile_wr_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for regfile32: round-robin arbitration between ALU (A) and
// load (B) writeback, plus a sequenced clear of registers 1..NREG-1 after reset or on request.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              D_En,
  output logic [ADDR_W-1:0] D_Addr,
  output logic [DATA_W-1:0] D
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              rr;
  logic              run;

  assign run      = (state == ST_RUN);
  assign clr_busy = (state == ST_CLEAR);

  // Grants are combinational so a requester sees its handshake in the same cycle.
  assign a_ready = run & ~clr_start & a_valid & (~b_valid | (rr == RR_A));
  assign b_ready = run & ~clr_start & b_valid & (~a_valid | (rr == RR_B));

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_CLEAR;
      cnt    <= FIRST_ADDR;
      rr     <= RR_A;
      D_En   <= 1'b0;
      D_Addr <= '0;
      D      <= '0;
    end else if (state == ST_CLEAR) begin
      D_En   <= 1'b1;
      D_Addr <= cnt;
      D      <= '0;
      if (cnt == LAST_ADDR) begin
        state <= ST_RUN;
        cnt   <= FIRST_ADDR;
      end else begin
        cnt <= cnt + FIRST_ADDR;
      end
    end else if (clr_start) begin
      state <= ST_CLEAR;
      cnt   <= FIRST_ADDR;
      D_En  <= 1'b0;
    end else if (a_ready) begin
      // Address 0 is hardwired in the register file: complete the handshake, drop the write.
      D_En   <= (a_addr != '0);
      D_Addr <= a_addr;
      D      <= a_data;
      if (b_valid) rr <= RR_B;
    end else if (b_ready) begin
      D_En   <= (b_addr != '0);
      D_Addr <= b_addr;
      D      <= b_data;
      if (a_valid) rr <= RR_A;
    end else begin
      D_En <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table, directed clear/reset
// sequences and a randomized run against a behavioural model.
module tb_regfile_wr_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk;
  logic              reset;
  logic              clr_start;
  logic              clr_busy;
  logic              a_valid, a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              D_En;
  logic [ADDR_W-1:0] D_Addr;
  logic [DATA_W-1:0] D;

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .D_En(D_En), .D_Addr(D_Addr), .D(D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register file driven by the DUT outputs, used for readback checks.
  logic [DATA_W-1:0] dut_rf [NREG];
  always @(posedge clk or negedge reset) begin
    if (!reset) dut_rf[0] <= '0;
    else if (D_En) dut_rf[D_Addr] <= D;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode flag, next clear address, who wins the next conflict.
  bit                m_clear;
  int                m_next;
  bit                m_favor_b;
  bit                m_en;
  int                m_addr;
  logic [DATA_W-1:0] m_d;
  bit                last_ga, last_gb;
  logic              got_a, got_b;

  task automatic model_reset();
    m_clear   = 1'b1;
    m_next    = 1;
    m_favor_b = 1'b0;
    m_en      = 1'b0;
    m_addr    = 0;
    m_d       = '0;
  endtask

  task automatic model_grants(output bit ga, output bit gb);
    ga = 1'b0;
    gb = 1'b0;
    if (!m_clear && !clr_start) begin
      if (a_valid && b_valid) begin
        if (m_favor_b) gb = 1'b1;
        else ga = 1'b1;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
    end
  endtask

  task automatic model_edge(input bit ga, input bit gb);
    if (m_clear) begin
      m_en   = 1'b1;
      m_addr = m_next;
      m_d    = '0;
      if (m_next == NREG - 1) begin
        m_clear = 1'b0;
        m_next  = 1;
      end else begin
        m_next = m_next + 1;
      end
    end else if (clr_start) begin
      m_clear = 1'b1;
      m_next  = 1;
      m_en    = 1'b0;
    end else if (ga || gb) begin
      m_addr = ga ? int'(a_addr) : int'(b_addr);
      m_d    = ga ? a_data : b_data;
      m_en   = (m_addr != 0);
      if (a_valid && b_valid) m_favor_b = ga;
    end else begin
      m_en = 1'b0;
    end
  endtask

  // One clock: starts at posedge+1 with inputs already applied.
  task automatic cycle();
    bit ga, gb;
    #4;
    model_grants(ga, gb);
    got_a = a_ready;
    got_b = b_ready;
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    @(posedge clk);
    model_edge(ga, gb);
    last_ga = ga;
    last_gb = gb;
    #1;
    check("D_En", D_En, m_en);
    check("D_Addr", D_Addr, m_addr);
    check("D", D, m_d);
    check("clr_busy", clr_busy, m_clear);
  endtask

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              ea, eb, en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
  } vec_t;

  vec_t vecs[10];
  int   ready_hits;

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[3] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    vecs[4] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[5] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234};
    vecs[7] = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
    vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
    vecs[9] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11};

    clr_start = 1'b0;
    a_valid = 1'b1; a_addr = '0; a_data = '0;
    b_valid = 1'b1; b_addr = '0; b_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst D_En", D_En, 1'b0);
    check("rst D_Addr", D_Addr, 0);
    check("rst D", D, 0);
    check("rst clr_busy", clr_busy, 1'b1);
    check("rst a_ready", a_ready, 1'b0);
    check("rst b_ready", b_ready, 1'b0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset = 1'b1;

    // Power-on clear walk.
    for (int k = 1; k < NREG; k++) begin
      cycle();
      check("init clr addr", D_Addr, k);
      check("init clr en", D_En, 1'b1);
    end
    check("init clr_busy low", clr_busy, 1'b0);
    cycle();
    for (int r = 0; r < NREG; r++) check("rf zero after clear", dut_rf[r], 0);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      cycle();
      check("vec a_ready", got_a, vecs[i].ea);
      check("vec b_ready", got_b, vecs[i].eb);
      check("vec D_En", D_En, vecs[i].en);
      check("vec D_Addr", D_Addr, vecs[i].addr);
      check("vec D", D, vecs[i].d);
      if (i == 1) check("rf5 readback", dut_rf[5], 32'hDEADBEEF);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    cycle();
    check("rf0 stays 0", dut_rf[0], 0);
    check("rf4 last B", dut_rf[4], 32'h44);
    check("rf3 last A", dut_rf[3], 32'h33);

    // clr_start pulse with A held: no grant for 32 cycles, then A accepted.
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0A0A0A0;
    clr_start = 1'b1;
    ready_hits = 0;
    cycle();
    if (got_a) ready_hits++;
    clr_start = 1'b0;
    for (int k = 1; k < NREG; k++) begin
      cycle();
      if (got_a) ready_hits++;
      check("req clr addr", D_Addr, k);
    end
    check("a_ready held off", ready_hits, 0);
    cycle();
    check("first RUN grant", got_a, 1'b1);
    check("first RUN addr", D_Addr, 10);
    a_valid = 1'b0;
    cycle();
    for (int r = 1; r < NREG; r++)
      if (r != 10) check("rf cleared", dut_rf[r], 0);

    // Reset in the middle of a clear walk.
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    for (int k = 1; k <= 12; k++) cycle();
    check("mid clr addr 12", D_Addr, 12);
    a_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrst D_En", D_En, 1'b0);
    check("midrst D_Addr", D_Addr, 0);
    check("midrst D", D, 0);
    check("midrst clr_busy", clr_busy, 1'b1);
    check("midrst a_ready", a_ready, 1'b0);
    model_reset();
    a_valid = 1'b0;
    #1 reset = 1'b1;
    cycle();
    check("restart addr 1", D_Addr, 1);
    for (int k = 2; k < NREG; k++) cycle();

    // Randomized traffic with well-behaved requesters.
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (clr_start) clr_start = 1'b0;
      else clr_start = ($urandom_range(0, 49) == 0);
      cycle();
      if (!a_valid || last_ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        a_data  = $urandom;
      end
      if (!b_valid || last_gb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        b_data  = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
